// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch stage: opcode constants, FSM states,
// and the IF/ID bundle.
package instruction_fetch_pkg;

  localparam int         DATA_SIZE = 16;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_SIZE-1:0] instr;
    logic [DATA_SIZE-1:0] pc;
    logic [DATA_SIZE-1:0] pc_plus1;
    logic                 valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register with bubble (highest), load and hold.
// A bubble clears instruction/valid and keeps the PC fields.
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q.instr    <= NOP_INSTR;
      reg_q.pc       <= '0;
      reg_q.pc_plus1 <= '0;
      reg_q.valid    <= 1'b0;
    end else if (bubble) begin
      reg_q.instr <= NOP_INSTR;
      reg_q.valid <= 1'b0;
    end else if (load) begin
      reg_q <= d;
    end
  end

  assign q = reg_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and BOOT/RUN/HALTED FSM, feeds the
// asynchronous instruction memory and fills the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_mode,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_instruction,
  output logic [15:0] if_id_instruction,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         load, bubble;
  if_id_t       cap, if_id;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load         = 1'b0;
    bubble       = 1'b0;
    cap.instr    = imem_instruction;
    cap.pc       = pc_q;
    cap.pc_plus1 = pc_q + 16'd1;
    cap.valid    = 1'b1;
    unique case (state_q)
      FETCH_BOOT: begin
        bubble = 1'b1;
        pc_d   = RESET_PC;
        if (!load_mode) state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (load_mode) begin
          state_d = FETCH_BOOT;
          pc_d    = RESET_PC;
          bubble  = 1'b1;
        end else if (branch_taken) begin
          pc_d   = branch_target;
          bubble = 1'b1;
        end else if (!stall) begin
          load = 1'b1;
          // HALT is captured but the PC stays parked on it
          if (imem_instruction[15:12] == OP_HALT)
            state_d = FETCH_HALTED;
          else
            pc_d = pc_q + 16'd1;
        end
      end
      FETCH_HALTED: begin
        bubble = 1'b1;
        if (load_mode) begin
          state_d = FETCH_BOOT;
          pc_d    = RESET_PC;
        end else if (branch_taken) begin
          state_d = FETCH_RUN;
          pc_d    = branch_target;
        end
      end
      default: begin
        state_d = FETCH_BOOT;
        pc_d    = RESET_PC;
        bubble  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .bubble (bubble),
    .d      (cap),
    .q      (if_id)
  );

  assign imem_address      = pc_q;
  assign if_id_instruction = if_id.instr;
  assign if_id_pc          = if_id.pc;
  assign if_id_pc_plus1    = if_id.pc_plus1;
  assign if_id_valid       = if_id.valid;
  assign halted            = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch against a
// behavioural fetch model.
module tb_instruction_fetch;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] RPC = 16'h0000;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_mode = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic [15:0] imem_address;
  logic [15:0] imem_instruction;
  logic [15:0] if_id_instruction;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        halted;

  logic [15:0] mem [0:65535];

  int          checks = 0;
  int          errors = 0;

  int          m_mode;
  logic [15:0] m_pc;
  logic [15:0] e_instr, e_pc, e_p1;
  logic        e_valid;

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_address];

  instruction_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_mode         (load_mode),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus1    (if_id_pc_plus1),
    .if_id_valid       (if_id_valid),
    .halted            (halted)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"}, imem_address, m_pc);
    check({tag, ".instr"}, if_id_instruction, e_instr);
    check({tag, ".pc"}, if_id_pc, e_pc);
    check({tag, ".pc1"}, if_id_pc_plus1, e_p1);
    check({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, e_valid});
    check({tag, ".halted"}, {15'd0, halted},
          {15'd0, (m_mode == M_HALT)});
  endtask

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_pc    = RPC;
    e_instr = NOP;
    e_pc    = 16'h0;
    e_p1    = 16'h0;
    e_valid = 1'b0;
  endtask

  task automatic model_bubble();
    e_instr = NOP;
    e_valid = 1'b0;
  endtask

  // One clock edge of the fetch rules applied to the model.
  task automatic model_edge(input logic ld, input logic st,
                            input logic br, input logic [15:0] tgt);
    logic [15:0] w;
    w = mem[m_pc];
    if (m_mode == M_BOOT) begin
      model_bubble();
      m_pc = RPC;
      if (!ld) m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      model_bubble();
      if (ld) begin
        m_mode = M_BOOT;
        m_pc = RPC;
      end else if (br) begin
        m_mode = M_RUN;
        m_pc = tgt;
      end
    end else if (ld) begin
      model_bubble();
      m_mode = M_BOOT;
      m_pc = RPC;
    end else if (br) begin
      model_bubble();
      m_pc = tgt;
    end else if (!st) begin
      e_instr = w;
      e_pc    = m_pc;
      e_p1    = 16'((int'(m_pc) + 1) % 65536);
      e_valid = 1'b1;
      if (w[15:12] == 4'hF) m_mode = M_HALT;
      else m_pc = e_p1;
    end
  endtask

  task automatic step(input string tag, input logic ld, input logic st,
                      input logic br, input logic [15:0] tgt);
    load_mode     = ld;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    model_edge(ld, st, br, tgt);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = 16'($urandom) & 16'hEFFF;
    mem[0]     = 16'h1111;
    mem[1]     = 16'h2222;
    mem[2]     = 16'h3333;
    mem[3]     = 16'hF000;
    mem[16'h0025] = 16'h2525;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // boot exit then sequential fetch
    step("boot_exit", 0, 0, 0, 16'h0);
    check("boot_exit_valid", {15'd0, if_id_valid}, 16'h0);
    step("f0", 0, 0, 0, 16'h0);
    check("f0_instr", if_id_instruction, 16'h1111);
    check("f0_pc", if_id_pc, 16'h0000);
    step("f1", 0, 0, 0, 16'h0);
    check("f1_instr", if_id_instruction, 16'h2222);

    // stall 3 cycles holds 2222 / pc 1
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 0, 16'h0);
      check("stall_instr", if_id_instruction, 16'h2222);
      check("stall_pc", if_id_pc, 16'h0001);
    end
    step("f2", 0, 0, 0, 16'h0);
    check("f2_instr", if_id_instruction, 16'h3333);
    check("f2_pc", if_id_pc, 16'h0002);

    // stall + branch together: branch wins
    step("stbr", 0, 1, 1, 16'h0040);
    check("stbr_valid", {15'd0, if_id_valid}, 16'h0);
    check("stbr_instr", if_id_instruction, NOP);
    step("tgt40", 0, 0, 0, 16'h0);
    check("tgt40_pc", if_id_pc, 16'h0040);
    check("tgt40_instr", if_id_instruction, mem[16'h0040]);

    // back-to-back branches, last one wins, ends at HALT
    step("bb1", 0, 0, 1, 16'h0080);
    step("bb2", 0, 0, 1, 16'h0003);
    step("halt_cap", 0, 0, 0, 16'h0);
    check("halt_instr", if_id_instruction, 16'hF000);
    check("halt_valid", {15'd0, if_id_valid}, 16'h1);
    check("halt_flag", {15'd0, halted}, 16'h1);
    for (int i = 0; i < 3; i++) begin
      step("halted", 0, i[0], 0, 16'h0);
      check("halted_addr", imem_address, 16'h0003);
    end
    step("unhalt", 0, 0, 1, 16'h0010);
    step("resume", 0, 0, 0, 16'h0);
    check("resume_pc", if_id_pc, 16'h0010);

    // wrap at 16'hFFFF
    step("brwrap", 0, 0, 1, 16'hFFFF);
    step("wrap", 0, 0, 0, 16'h0);
    check("wrap_p1", if_id_pc_plus1, 16'h0000);
    check("wrap_addr", imem_address, 16'h0000);

    // load_mode mid-run at pc 0x25
    step("br25", 0, 0, 1, 16'h0025);
    step("ld_on", 1, 0, 0, 16'h0);
    check("ld_addr", imem_address, RPC);
    check("ld_valid", {15'd0, if_id_valid}, 16'h0);
    step("ld_hold", 1, 0, 0, 16'h0);
    step("ld_off", 0, 0, 0, 16'h0);
    step("refetch", 0, 0, 0, 16'h0);
    check("refetch_instr", if_id_instruction, 16'h1111);

    // async reset in the middle of a stall
    step("pre_st", 0, 0, 0, 16'h0);
    step("mid_st", 0, 1, 0, 16'h0);
    async_reset("rst_mid_stall");
    check("rst_valid", {15'd0, if_id_valid}, 16'h0);
    step("rst_boot", 0, 0, 0, 16'h0);
    step("rst_f0", 0, 0, 0, 16'h0);
    check("rst_f0_instr", if_id_instruction, 16'h1111);

    // randomized phase with sprinkled HALTs
    for (int i = 0; i < 1024; i++)
      if ($urandom_range(15) == 0) mem[i] = 16'hF000 | 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      logic ld, st, br;
      logic [15:0] tg;
      ld = ($urandom_range(39) == 0);
      st = ($urandom_range(3) == 0);
      br = ($urandom_range(7) == 0);
      tg = 16'($urandom_range(1023));
      if ($urandom_range(199) == 0) async_reset("rnd_rst");
      else step("rnd", ld, st, br, tg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
